// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and NOP bubbles.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer with a registered in_ready_o.
module pipe_stage_reg #(
    parameter int unsigned    DW      = 64,
    parameter logic [DW-1:0]  NOP_VAL = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [1:0]    occupancy_o
);

    logic          main_valid, main_valid_nxt;
    logic [DW-1:0] main_data, main_data_nxt;
    logic          in_fire, out_fire;

    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = main_valid & out_ready_i;
    assign out_valid_o = main_valid;
    assign out_data_o  = main_data;

`ifdef PIPE_STAGE_SKID_EN
    logic          skid_valid, skid_valid_nxt;
    logic [DW-1:0] skid_data, skid_data_nxt;

    assign in_ready_o  = !skid_valid;
    assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};

    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    always_comb begin
        main_valid_nxt = main_valid;
        main_data_nxt  = main_data;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        if (flush_i) begin
            main_valid_nxt = 1'b0;
            main_data_nxt  = NOP_VAL;
            skid_valid_nxt = 1'b0;
            skid_data_nxt  = NOP_VAL;
        end else if (!main_valid || out_fire) begin
            if (skid_valid) begin
                main_valid_nxt = 1'b1;
                main_data_nxt  = skid_data;
                skid_valid_nxt = 1'b0;
                skid_data_nxt  = NOP_VAL;
            end else if (in_fire) begin
                main_valid_nxt = 1'b1;
                main_data_nxt  = in_data_i;
            end else begin
                main_valid_nxt = 1'b0;
                main_data_nxt  = NOP_VAL;
            end
        end else if (in_fire) begin
            // Main is stalled: the beat accepted this cycle parks in the skid entry.
            skid_valid_nxt = 1'b1;
            skid_data_nxt  = in_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_valid <= 1'b0;
            skid_data  <= NOP_VAL;
        end else begin
            skid_valid <= skid_valid_nxt;
            skid_data  <= skid_data_nxt;
        end
    end
`else
    assign in_ready_o  = !main_valid || out_ready_i;
    assign occupancy_o = {1'b0, main_valid};

    always_comb begin
        main_valid_nxt = main_valid;
        main_data_nxt  = main_data;
        if (flush_i) begin
            main_valid_nxt = 1'b0;
            main_data_nxt  = NOP_VAL;
        end else if (!main_valid || out_fire) begin
            main_valid_nxt = in_fire;
            main_data_nxt  = in_fire ? in_data_i : NOP_VAL;
        end
    end
`endif

    // NOTE: payload registers are reset too, because out_data_o must show NOP_VAL, never stale data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            main_valid <= 1'b0;
            main_data  <= NOP_VAL;
        end else begin
            main_valid <= main_valid_nxt;
            main_data  <= main_data_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a queue of held beats models the stage's contents.
module tb_pipe_stage_reg;

    localparam int             DW  = 32;
    localparam logic [DW-1:0]  NOP = 32'h0000_0013;

    logic          clk         = 1'b0;
    logic          rst         = 1'b0;
    logic          flush_i     = 1'b0;
    logic          in_valid_i  = 1'b0;
    logic [DW-1:0] in_data_i   = '0;
    logic          out_ready_i = 1'b0;
    logic          in_ready_o;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic [1:0]    occupancy_o;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] q[$];

    pipe_stage_reg #(.DW(DW), .NOP_VAL(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .occupancy_o (occupancy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the queue holds exactly the beats the stage should hold after the last edge.
    always @(negedge clk) begin
        int  n;
        logic exp_ready;
        n = q.size();
`ifdef PIPE_STAGE_SKID_EN
        exp_ready = (n < 2);
`else
        exp_ready = (n == 0) || out_ready_i;
`endif
        check("occupancy", 64'(occupancy_o), 64'(n));
        check("out_valid", 64'(out_valid_o), 64'(n > 0));
        check("out_data", 64'(out_data_o), 64'((n > 0) ? q[0] : NOP));
        check("in_ready", 64'(in_ready_o), 64'(exp_ready));
        if (rst && out_valid_o && out_ready_i && n > 0) void'(q.pop_front());
    end

    // Reference model: after delivery has been scored, record what the upcoming edge accepts.
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            if (flush_i) q.delete();
            else if (in_valid_i && in_ready_o) q.push_back(in_data_i);
        end
    end

    always @(negedge rst) q.delete();

    // Called at posedge+1; drives one cycle and reports whether the beat was accepted.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy,
                        input logic fl, output logic acc);
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = ordy;
        flush_i     = fl;
        #3;
        acc = v && in_ready_o && rst;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic acc;
        int   c = 0;
        while (q.size() != 0 && c < 20) begin
            step(1'b0, '0, 1'b1, 1'b0, acc);
            c++;
        end
        check("drain_done", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic          acc;
        int            idx;
        logic [DW-1:0] bp[3];

        // Reset held low with random inputs
        repeat (4) begin
            @(posedge clk);
            #1;
            in_valid_i  = 1'($urandom);
            in_data_i   = $urandom;
            out_ready_i = 1'($urandom);
            flush_i     = 1'($urandom);
            #3;
            check("rst_valid", 64'(out_valid_o), 64'd0);
            check("rst_data", 64'(out_data_o), 64'(NOP));
            check("rst_ready", 64'(in_ready_o), 64'd1);
            check("rst_occ", 64'(occupancy_o), 64'd0);
        end
        in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back stream
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, DW'(i), 1'b1, 1'b0, acc);
            check("stream_accept", 64'(acc), 64'd1);
            check("stream_latency", 64'(out_data_o), 64'(i));
        end
        drain();

        // Backpressure
        bp[0] = 32'h10; bp[1] = 32'h11; bp[2] = 32'h12;
        idx = 0;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            if (c == 2) begin
`ifdef PIPE_STAGE_SKID_EN
                check("bp_occ_full", 64'(occupancy_o), 64'd2);
                check("bp_ready_low", 64'(in_ready_o), 64'd0);
`else
                check("bp_occ_single", 64'(occupancy_o), 64'd1);
                check("bp_ready_low", 64'(in_ready_o), 64'd0);
`endif
            end
            step(1'b1, bp[idx], (c >= 1 && c <= 3) ? 1'b0 : 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        check("bp_all_sent", 64'(idx), 64'd3);
        drain();

        // in_ready dependence on out_ready within a cycle while main is valid
        step(1'b1, 32'h55, 1'b0, 1'b0, acc);
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        #1;
`ifdef PIPE_STAGE_SKID_EN
        check("ready_reg_lo", 64'(in_ready_o), 64'd1);
`else
        check("ready_comb_lo", 64'(in_ready_o), 64'd0);
`endif
        out_ready_i = 1'b1;
        #1;
        check("ready_comb_hi", 64'(in_ready_o), 64'd1);
        @(posedge clk);
        #1;
        drain();

        // Flush with a beat handshaking the same cycle
        step(1'b1, 32'h40, 1'b0, 1'b0, acc);
        step(1'b1, 32'h41, 1'b0, 1'b0, acc);
        step(1'b1, 32'hAA, 1'b0, 1'b1, acc);
        check("flush_valid", 64'(out_valid_o), 64'd0);
        check("flush_data", 64'(out_data_o), 64'(NOP));
        check("flush_occ", 64'(occupancy_o), 64'd0);
        check("flush_ready", 64'(in_ready_o), 64'd1);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0, acc);

        // Asynchronous reset mid-stream, away from the clock edge
        step(1'b1, 32'h30, 1'b0, 1'b0, acc);
        step(1'b1, 32'h31, 1'b0, 1'b0, acc);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid_o), 64'd0);
        check("arst_data", 64'(out_data_o), 64'(NOP));
        check("arst_occ", 64'(occupancy_o), 64'd0);
        check("arst_ready", 64'(in_ready_o), 64'd1);
        in_valid_i = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 32'h20, 1'b1, 1'b0, acc);
        check("post_rst_20", 64'(out_data_o), 64'h20);
        step(1'b1, 32'h21, 1'b1, 1'b0, acc);
        check("post_rst_21", 64'(out_data_o), 64'h21);
        drain();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0, acc);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
